// File: rtl/ws2812_pkg.sv
// ws2812_pkg: definitions shared by the WS2812 receiver and transmitter.
//   - state_t        : receiver decode states
//   - PIXEL_BITS     : bits per GRB pixel
//   - 16 MHz timing  : one source for T0H/T1H/bit period/latch gap on both ends
//   - sat_sum()      : saturating add used by the level-duration counter
package ws2812_pkg;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,  // waiting for a full latch gap before trusting the line
      ST_IDLE = 2'd1,  // between frames, waiting for the first rising edge
      ST_HIGH = 2'd2,  // measuring a high pulse
      ST_LOW  = 2'd3   // measuring the low time after a pulse
   } state_t;

   localparam int PIXEL_BITS = 24;
   localparam int BIT_CNT_W  = $clog2(PIXEL_BITS);
   localparam int CNT_W      = 16;

   // 16 MHz line timing, in clock cycles
   localparam int T0H_CYCLES       = 6;
   localparam int T1H_CYCLES       = 13;
   localparam int BIT_CYCLES       = 20;
   localparam int RESET_CYCLES_DEF = 800;

   // Receiver decisions: threshold sits midway between T0H and T1H
   localparam int BIT_THRESH_DEF = (T0H_CYCLES + T1H_CYCLES + 1) / 2;
   localparam int MIN_HIGH_DEF   = 2;
   localparam int MAX_HIGH_DEF   = 32;

   function automatic logic [CNT_W-1:0] sat_sum(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b,
                                                input logic             cin);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b} + {{CNT_W{1'b0}}, cin};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/ws2812_rx_sync_edge.sv
// sync_edge: 2-FF synchronizer for an asynchronous pin plus registered
// rise/fall strobes. o_level is the delayed synchronized level, aligned so
// that a strobe and the new level appear in the same cycle.
//   i_clk    in  clock
//   i_rst_n  in  asynchronous active-low reset
//   i_din    in  asynchronous pin
//   o_level  out synchronized level (aligned with the strobes)
//   o_rise   out one-cycle strobe on a 0->1 transition
//   o_fall   out one-cycle strobe on a 1->0 transition
module sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_din,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta, r_sync, r_prev, r_rise, r_fall;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its source, which is what makes the
   // synchronizer chain a chain rather than a single wire.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_meta <= i_din;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
         r_fall <= ~r_sync & r_prev;
      end
   end

   assign o_level = r_prev;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NRZ pulse-width decoder. Classifies each high pulse as a
// 0 or 1 bit, assembles 24-bit GRB pixels and reports frame ends on the
// latch gap.
//   CLK           in  system clock
//   RST_N         in  asynchronous active-low reset
//   DIN           in  asynchronous serial LED data
//   pixel_valid   out one-cycle strobe, pixel_data/pixel_index valid
//   pixel_data    out {G,R,B}, first received bit in bit 23
//   pixel_index   out 0-based pixel position within the frame
//   frame_done    out one-cycle strobe at frame end
//   frame_pixels  out pixels in the frame just ended (held)
//   frame_err     out sticky error, cleared by the next frame's first edge
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int unsigned BIT_THRESH   = BIT_THRESH_DEF,
   parameter int unsigned MIN_HIGH     = MIN_HIGH_DEF,
   parameter int unsigned MAX_HIGH     = MAX_HIGH_DEF,
   parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF,
   parameter int unsigned IDX_W        = 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  DIN,
   output logic                  pixel_valid,
   output logic [PIXEL_BITS-1:0] pixel_data,
   output logic [IDX_W-1:0]      pixel_index,
   output logic                  frame_done,
   output logic [IDX_W-1:0]      frame_pixels,
   output logic                  frame_err
);

   localparam logic [CNT_W-1:0] C_THRESH = CNT_W'(BIT_THRESH);
   localparam logic [CNT_W-1:0] C_MIN    = CNT_W'(MIN_HIGH);
   localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(MAX_HIGH);
   localparam logic [CNT_W-1:0] C_RESET  = CNT_W'(RESET_CYCLES);

   logic w_level, w_rise, w_fall;

   state_t r_state, w_next_state;

   logic [CNT_W-1:0]      r_cnt, r_low_save;
   logic [PIXEL_BITS-1:0] r_shift, r_pixel_data;
   logic [BIT_CNT_W-1:0]  r_bit_cnt;
   logic [IDX_W-1:0]      r_idx, r_pixel_index, r_frame_pixels;
   logic                  r_pixel_valid, r_frame_done, r_err;

   logic w_frame_start, w_shift_en, w_bit, w_glitch, w_save_low;
   logic w_err_abort, w_frame_end, w_frame_empty;
   logic [PIXEL_BITS-1:0] w_shift_next;

   sync_edge u_sync (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_din   (DIN),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   assign w_shift_next  = {r_shift[PIXEL_BITS-2:0], w_bit};
   assign w_frame_empty = (r_bit_cnt == '0) && (r_idx == '0);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= ST_SYNC;
      else        r_state <= w_next_state;
   end

   // NOTE: every signal written here gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      w_next_state  = r_state;
      w_frame_start = 1'b0;
      w_shift_en    = 1'b0;
      w_bit         = 1'b0;
      w_glitch      = 1'b0;
      w_save_low    = 1'b0;
      w_err_abort   = 1'b0;
      w_frame_end   = 1'b0;
      unique case (r_state)
         ST_SYNC: begin
            if (!w_level && r_cnt >= C_RESET) w_next_state = ST_IDLE;
         end
         ST_IDLE: begin
            if (w_rise) begin
               w_frame_start = 1'b1;
               w_next_state  = ST_HIGH;
            end
         end
         ST_HIGH: begin
            // A pulse that has lasted MAX_HIGH is an error even if it ends now.
            if (r_cnt >= C_MAX) begin
               w_err_abort  = 1'b1;
               w_next_state = ST_SYNC;
            end else if (w_fall) begin
               if (r_cnt < C_MIN) begin
                  w_glitch = 1'b1;
                  // A glitch as the very first pulse must not open a frame.
                  w_next_state = w_frame_empty ? ST_IDLE : ST_LOW;
               end else begin
                  w_shift_en   = 1'b1;
                  w_bit        = (r_cnt >= C_THRESH);
                  w_next_state = ST_LOW;
               end
            end
         end
         ST_LOW: begin
            if (w_rise) begin
               w_save_low   = 1'b1;
               w_next_state = ST_HIGH;
            end else if (r_cnt >= C_RESET) begin
               w_frame_end  = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_SYNC;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt          <= '0;
         r_low_save     <= '0;
         r_shift        <= '0;
         r_bit_cnt      <= '0;
         r_idx          <= '0;
         r_pixel_valid  <= 1'b0;
         r_pixel_data   <= '0;
         r_pixel_index  <= '0;
         r_frame_done   <= 1'b0;
         r_frame_pixels <= '0;
         r_err          <= 1'b0;
      end else begin
         r_pixel_valid <= 1'b0;
         r_frame_done  <= 1'b0;

         // Level duration. A rejected glitch resumes the low count as if the
         // pulse never happened: saved low time + glitch width + this cycle.
         if (w_glitch)                r_cnt <= sat_sum(r_low_save, r_cnt, 1'b1);
         else if (w_rise || w_fall)   r_cnt <= CNT_W'(1);
         else if (r_cnt != '1)        r_cnt <= r_cnt + CNT_W'(1);

         if (w_save_low) r_low_save <= r_cnt;

         if (w_frame_start) begin
            r_idx     <= '0;
            r_bit_cnt <= '0;
            r_err     <= 1'b0;
         end

         if (w_shift_en) begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == BIT_CNT_W'(PIXEL_BITS - 1)) begin
               r_bit_cnt     <= '0;
               r_pixel_valid <= 1'b1;
               r_pixel_data  <= w_shift_next;
               r_pixel_index <= r_idx;
               if (r_idx == '1) r_err <= 1'b1;
               else             r_idx <= r_idx + IDX_W'(1);
            end else begin
               r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
         end

         if (w_err_abort) r_err <= 1'b1;

         if (w_frame_end) begin
            r_frame_done   <= 1'b1;
            r_frame_pixels <= r_idx;
            if (r_bit_cnt != '0) begin
               r_err     <= 1'b1;
               r_bit_cnt <= '0;
            end
         end
      end
   end

   assign pixel_valid  = r_pixel_valid;
   assign pixel_data   = r_pixel_data;
   assign pixel_index  = r_pixel_index;
   assign frame_done   = r_frame_done;
   assign frame_pixels = r_frame_pixels;
   assign frame_err    = r_err;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: self-checking bench for ws2812_rx. Drives WS2812 waveforms,
// logs pixel/frame strobes, and compares against expectations built from the
// bits that were sent.
module tb_ws2812_rx;

   localparam int IDX_W = 8;
   localparam int GAP   = 830;

   logic              CLK   = 1'b0;
   logic              RST_N = 1'b0;
   logic              DIN   = 1'b0;
   logic              pixel_valid;
   logic [23:0]       pixel_data;
   logic [IDX_W-1:0]  pixel_index;
   logic              frame_done;
   logic [IDX_W-1:0]  frame_pixels;
   logic              frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int last_fall = 0;

   typedef struct { logic [23:0] data; logic [IDX_W-1:0] idx; int cyc; } pix_t;
   typedef struct { logic [IDX_W-1:0] pixels; logic err; int cyc; } frm_t;

   pix_t pq[$];
   frm_t fq[$];

   // Reference model state: bits sent in the current frame, and the pixels
   // and error flag they imply.
   logic        sent_bits[$];
   logic [23:0] exp_px[$];
   logic        exp_err;

   ws2812_rx #(
      .BIT_THRESH   (10),
      .MIN_HIGH     (2),
      .MAX_HIGH     (32),
      .RESET_CYCLES (800),
      .IDX_W        (IDX_W)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .DIN          (DIN),
      .pixel_valid  (pixel_valid),
      .pixel_data   (pixel_data),
      .pixel_index  (pixel_index),
      .frame_done   (frame_done),
      .frame_pixels (frame_pixels),
      .frame_err    (frame_err)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (pixel_valid) pq.push_back('{data: pixel_data, idx: pixel_index, cyc: cyc});
      if (frame_done)  fq.push_back('{pixels: frame_pixels, err: frame_err, cyc: cyc});
   end

   // ---------------- stimulus helpers ----------------
   task automatic hold(input logic v, input int n);
      DIN = v;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_bit(input logic b, input int th, input int tl);
      hold(1'b1, th);
      last_fall = cyc;
      hold(1'b0, tl);
   endtask

   task automatic send_rand_bit(input logic b);
      int th;
      th = b ? int'($urandom_range(24, 11)) : int'($urandom_range(8, 3));
      send_bit(b, th, int'($urandom_range(12, 4)));
      sent_bits.push_back(b);
   endtask

   task automatic send_fixed_bit(input logic b);
      send_bit(b, b ? 13 : 6, b ? 7 : 14);
      sent_bits.push_back(b);
   endtask

   task automatic send_pixel(input logic [23:0] d, input bit rnd);
      for (int i = 23; i >= 0; i--) begin
         if (rnd) send_rand_bit(d[i]);
         else     send_fixed_bit(d[i]);
      end
   endtask

   // Model: group sent bits into 24-bit pixels, MSB first; leftovers are an error.
   function automatic void model_frame();
      logic [23:0] acc;
      int k;
      acc = '0;
      k   = 0;
      exp_px.delete();
      foreach (sent_bits[i]) begin
         acc = {acc[22:0], sent_bits[i]};
         k++;
         if (k == 24) begin
            exp_px.push_back(acc);
            k = 0;
         end
      end
      exp_err = (k != 0);
   endfunction

   function automatic void clear_logs();
      pq.delete();
      fq.delete();
      sent_bits.delete();
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      RST_N = 1'b0;
      DIN   = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      n_checks++; if (pixel_valid !== 1'b0)  begin n_errors++; $display("FAIL reset_pixel_valid: got %b want 0", pixel_valid); end
      n_checks++; if (pixel_data !== 24'h0)  begin n_errors++; $display("FAIL reset_pixel_data: got %h want 0", pixel_data); end
      n_checks++; if (pixel_index !== '0)    begin n_errors++; $display("FAIL reset_pixel_index: got %0d want 0", pixel_index); end
      n_checks++; if (frame_done !== 1'b0)   begin n_errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      n_checks++; if (frame_pixels !== '0)   begin n_errors++; $display("FAIL reset_frame_pixels: got %0d want 0", frame_pixels); end
      n_checks++; if (frame_err !== 1'b0)    begin n_errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      RST_N = 1'b1;
      clear_logs();
      hold(1'b0, GAP);
      n_checks++; if (fq.size() != 0) begin n_errors++; $display("FAIL reset_sync_no_frame_done: got %0d want 0", fq.size()); end
   endtask

   task automatic test_single_pixel();
      int t_fall;
      clear_logs();
      send_pixel(24'hFF00A5, 1'b0);
      t_fall = last_fall;
      hold(1'b0, GAP);
      n_checks++; if (pq.size() != 1) begin n_errors++; $display("FAIL single_count: got %0d want 1", pq.size()); end
      if (pq.size() > 0) begin
         n_checks++; if (pq[0].data !== 24'hFF00A5) begin n_errors++; $display("FAIL single_data: got %h want ff00a5", pq[0].data); end
         n_checks++; if (pq[0].idx !== '0) begin n_errors++; $display("FAIL single_index: got %0d want 0", pq[0].idx); end
         n_checks++; if (pq[0].cyc - t_fall != 4) begin n_errors++; $display("FAIL single_latency: got %0d want 4", pq[0].cyc - t_fall); end
      end
      n_checks++; if (fq.size() != 1) begin n_errors++; $display("FAIL single_frames: got %0d want 1", fq.size()); end
      if (fq.size() > 0) begin
         n_checks++; if (fq[0].pixels !== IDX_W'(1)) begin n_errors++; $display("FAIL single_frame_pixels: got %0d want 1", fq[0].pixels); end
         n_checks++; if (fq[0].err !== 1'b0) begin n_errors++; $display("FAIL single_frame_err: got %b want 0", fq[0].err); end
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] pix [3];
      pix[0] = 24'h000000;
      pix[1] = 24'hFFFFFF;
      pix[2] = 24'h123456;
      clear_logs();
      for (int i = 0; i < 3; i++) send_pixel(pix[i], 1'b0);
      hold(1'b0, GAP);
      n_checks++; if (pq.size() != 3) begin n_errors++; $display("FAIL b2b_count: got %0d want 3", pq.size()); end
      for (int i = 0; i < 3 && i < pq.size(); i++) begin
         n_checks++; if (pq[i].data !== pix[i]) begin n_errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, pq[i].data, pix[i]); end
         n_checks++; if (pq[i].idx !== IDX_W'(i)) begin n_errors++; $display("FAIL b2b_index[%0d]: got %0d want %0d", i, pq[i].idx, i); end
      end
      n_checks++; if (fq.size() != 1) begin n_errors++; $display("FAIL b2b_frames: got %0d want 1", fq.size()); end
      if (fq.size() > 0) begin
         n_checks++; if (fq[0].pixels !== IDX_W'(3)) begin n_errors++; $display("FAIL b2b_frame_pixels: got %0d want 3", fq[0].pixels); end
      end
   endtask

   task automatic test_glitch();
      logic [23:0] d;
      logic        b;
      d = 24'hABCDEF;
      clear_logs();
      for (int i = 0; i < 24; i++) begin
         b = d[23-i];
         if (i == 10) begin
            // 1-cycle high spike inside bit 10's low time, before bit 11
            send_bit(b, b ? 13 : 6, 5);
            hold(1'b1, 1);
            hold(1'b0, b ? 2 : 9);
            sent_bits.push_back(b);
         end else begin
            send_fixed_bit(b);
         end
      end
      hold(1'b0, GAP);
      n_checks++; if (pq.size() != 1) begin n_errors++; $display("FAIL glitch_count: got %0d want 1", pq.size()); end
      if (pq.size() > 0) begin
         n_checks++; if (pq[0].data !== 24'hABCDEF) begin n_errors++; $display("FAIL glitch_data: got %h want abcdef", pq[0].data); end
      end
      n_checks++; if (fq.size() != 1) begin n_errors++; $display("FAIL glitch_frames: got %0d want 1", fq.size()); end
      if (fq.size() > 0) begin
         n_checks++; if (fq[0].err !== 1'b0) begin n_errors++; $display("FAIL glitch_frame_err: got %b want 0", fq[0].err); end
      end
   endtask

   task automatic test_partial();
      logic [23:0] d;
      clear_logs();
      for (int i = 0; i < 12; i++) send_rand_bit(1'($urandom_range(1, 0)));
      hold(1'b0, GAP);
      n_checks++; if (pq.size() != 0) begin n_errors++; $display("FAIL partial_no_pixel: got %0d want 0", pq.size()); end
      n_checks++; if (fq.size() != 1) begin n_errors++; $display("FAIL partial_frames: got %0d want 1", fq.size()); end
      if (fq.size() > 0) begin
         n_checks++; if (fq[0].pixels !== '0) begin n_errors++; $display("FAIL partial_frame_pixels: got %0d want 0", fq[0].pixels); end
         n_checks++; if (fq[0].err !== 1'b1) begin n_errors++; $display("FAIL partial_frame_err: got %b want 1", fq[0].err); end
      end
      n_checks++; if (frame_err !== 1'b1) begin n_errors++; $display("FAIL partial_err_sticky: got %b want 1", frame_err); end
      // Next frame: first rising edge clears the error
      clear_logs();
      d = 24'($urandom()) | 24'h800000;
      hold(1'b1, 6);
      n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL partial_err_cleared: got %b want 0", frame_err); end
      hold(1'b1, 7);
      hold(1'b0, 7);
      sent_bits.push_back(1'b1);
      for (int i = 22; i >= 0; i--) send_fixed_bit(d[i]);
      hold(1'b0, GAP);
      n_checks++; if (pq.size() != 1) begin n_errors++; $display("FAIL partial_next_count: got %0d want 1", pq.size()); end
      if (pq.size() > 0) begin
         n_checks++; if (pq[0].data !== d) begin n_errors++; $display("FAIL partial_next_data: got %h want %h", pq[0].data, d); end
      end
   endtask

   task automatic test_stuck_high();
      logic [23:0] d;
      clear_logs();
      for (int i = 0; i < 8; i++) send_rand_bit(1'($urandom_range(1, 0)));
      hold(1'b1, 30);
      n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL stuck_err_early: got %b want 0", frame_err); end
      hold(1'b1, 10);
      n_checks++; if (frame_err !== 1'b1) begin n_errors++; $display("FAIL stuck_err_set: got %b want 1", frame_err); end
      hold(1'b0, 400);
      for (int i = 0; i < 5; i++) send_rand_bit(1'($urandom_range(1, 0)));
      hold(1'b0, 400);
      n_checks++; if (pq.size() != 0 || fq.size() != 0) begin n_errors++; $display("FAIL stuck_no_decode: got %0d/%0d want 0/0", pq.size(), fq.size()); end
      n_checks++; if (frame_err !== 1'b1) begin n_errors++; $display("FAIL stuck_err_held: got %b want 1", frame_err); end
      hold(1'b0, GAP);
      n_checks++; if (fq.size() != 0) begin n_errors++; $display("FAIL stuck_no_frame_done: got %0d want 0", fq.size()); end
      clear_logs();
      d = 24'h0F0F0F;
      send_pixel(d, 1'b0);
      hold(1'b0, GAP);
      n_checks++; if (pq.size() != 1) begin n_errors++; $display("FAIL stuck_next_count: got %0d want 1", pq.size()); end
      if (pq.size() > 0) begin
         n_checks++; if (pq[0].data !== d || pq[0].idx !== '0) begin n_errors++; $display("FAIL stuck_next_pixel: got %h@%0d want %h@0", pq[0].data, pq[0].idx, d); end
      end
      if (fq.size() > 0) begin
         n_checks++; if (fq[0].pixels !== IDX_W'(1) || fq[0].err !== 1'b0) begin n_errors++; $display("FAIL stuck_next_frame: got %0d/%b want 1/0", fq[0].pixels, fq[0].err); end
      end
   endtask

   task automatic test_random_frames();
      int npix, nextra;
      for (int f = 0; f < 4; f++) begin
         clear_logs();
         npix   = int'($urandom_range(3, 1));
         nextra = ($urandom_range(1, 0) == 1) ? int'($urandom_range(23, 1)) : 0;
         for (int p = 0; p < npix; p++) send_pixel(24'($urandom()), 1'b1);
         for (int b = 0; b < nextra; b++) send_rand_bit(1'($urandom_range(1, 0)));
         hold(1'b0, GAP);
         model_frame();
         n_checks++; if (pq.size() != exp_px.size()) begin n_errors++; $display("FAIL rand%0d_count: got %0d want %0d", f, pq.size(), exp_px.size()); end
         for (int i = 0; i < pq.size() && i < exp_px.size(); i++) begin
            n_checks++; if (pq[i].data !== exp_px[i] || pq[i].idx !== IDX_W'(i)) begin
               n_errors++; $display("FAIL rand%0d_pixel[%0d]: got %h@%0d want %h@%0d", f, i, pq[i].data, pq[i].idx, exp_px[i], i);
            end
         end
         n_checks++; if (fq.size() != 1) begin n_errors++; $display("FAIL rand%0d_frames: got %0d want 1", f, fq.size()); end
         if (fq.size() > 0) begin
            n_checks++; if (fq[0].pixels !== IDX_W'(exp_px.size()) || fq[0].err !== exp_err) begin
               n_errors++; $display("FAIL rand%0d_frame: got %0d/%b want %0d/%b", f, fq[0].pixels, fq[0].err, exp_px.size(), exp_err);
            end
         end
      end
   endtask

   task automatic test_midstream_reset();
      logic [23:0] p1, p2, p3;
      // Reset, then start streaming with no preceding latch gap
      RST_N = 1'b0;
      hold(1'b0, 2);
      RST_N = 1'b1;
      clear_logs();
      for (int i = 0; i < 10; i++) send_rand_bit(1'($urandom_range(1, 0)));
      send_pixel(24'($urandom()), 1'b1);
      send_pixel(24'($urandom()), 1'b1);
      hold(1'b0, 20);
      n_checks++; if (pq.size() != 0 || fq.size() != 0) begin n_errors++; $display("FAIL midstart_no_decode: got %0d/%0d want 0/0", pq.size(), fq.size()); end
      hold(1'b0, GAP);
      clear_logs();
      p1 = 24'($urandom());
      send_pixel(p1, 1'b1);
      n_checks++; if (pq.size() != 1 || (pq.size() > 0 && pq[0].data !== p1)) begin n_errors++; $display("FAIL midreset_first_pixel: got %0d strobes want 1 of %h", pq.size(), p1); end
      // Reset pulse during the high time of bit 5 of the next pixel
      clear_logs();
      p2 = 24'($urandom());
      for (int i = 23; i > 18; i--) send_fixed_bit(p2[i]);
      hold(1'b1, 3);
      RST_N = 1'b0;
      hold(1'b1, 2);
      n_checks++; if (pixel_data !== 24'h0 || pixel_index !== '0) begin n_errors++; $display("FAIL midreset_outputs: got %h@%0d want 000000@0", pixel_data, pixel_index); end
      n_checks++; if (frame_pixels !== '0 || frame_err !== 1'b0) begin n_errors++; $display("FAIL midreset_frame_outputs: got %0d/%b want 0/0", frame_pixels, frame_err); end
      RST_N = 1'b1;
      hold(1'b1, 8);
      hold(1'b0, 10);
      for (int i = 17; i >= 0; i--) send_fixed_bit(p2[i]);
      send_pixel(24'($urandom()), 1'b0);
      hold(1'b0, 20);
      n_checks++; if (pq.size() != 0 || fq.size() != 0) begin n_errors++; $display("FAIL midreset_no_decode: got %0d/%0d want 0/0", pq.size(), fq.size()); end
      hold(1'b0, GAP);
      n_checks++; if (fq.size() != 0) begin n_errors++; $display("FAIL midreset_no_frame_done: got %0d want 0", fq.size()); end
      clear_logs();
      p3 = 24'($urandom());
      send_pixel(p3, 1'b0);
      hold(1'b0, GAP);
      n_checks++; if (pq.size() != 1) begin n_errors++; $display("FAIL midreset_after_count: got %0d want 1", pq.size()); end
      if (pq.size() > 0) begin
         n_checks++; if (pq[0].data !== p3 || pq[0].idx !== '0) begin n_errors++; $display("FAIL midreset_after_pixel: got %h@%0d want %h@0", pq[0].data, pq[0].idx, p3); end
      end
      n_checks++; if (fq.size() != 1 || (fq.size() > 0 && fq[0].pixels !== IDX_W'(1))) begin n_errors++; $display("FAIL midreset_after_frame: got %0d frames want 1 with 1 pixel", fq.size()); end
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_back_to_back();
      test_glitch();
      test_partial();
      test_stuck_high();
      test_random_frames();
      test_midstream_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Single-wire WS2812 (NRZ pulse-width) decoder: the receive end of the LED data stream that the top-level driver emits on PIN_1.
- Samples the line with the system clock, classifies each high pulse as a 0 or 1 bit and assembles 24-bit GRB pixels.
- Reports each completed pixel, its index in the frame, and a frame-end event on the reset/latch gap.
- Used in loopback self-test on hardware and as the checker in top-level benches.

Parameters:
- BIT_THRESH, 10: high-time cycles at or above which a bit decodes as 1 (16 MHz: T0H≈6, T1H≈13).
- MIN_HIGH, 2: high pulses shorter than this are glitches and are ignored.
- MAX_HIGH, 32: high pulses reaching this length are a protocol error.
- RESET_CYCLES, 800: low time that marks latch/frame end (50 us at 16 MHz).
- IDX_W, 8: width of pixel index and count.

Ports:
- CLK  in  1  system clock (16 MHz).
- RST_N  in  1  asynchronous active-low reset.
- DIN  in  1  asynchronous serial LED data.
- pixel_valid  out  1  one-cycle strobe; pixel_data and pixel_index valid.
- pixel_data  out  24  {G[7:0],R[7:0],B[7:0]}, first received bit is bit 23.
- pixel_index  out  IDX_W  0-based pixel position within the frame.
- frame_done  out  1  one-cycle strobe at frame end.
- frame_pixels  out  IDX_W  pixels in the frame just ended; valid with frame_done, held afterwards.
- frame_err  out  1  sticky error; cleared at the first rising edge of the next frame.

Behaviour:
- Reset: all outputs 0; state SYNC; counters, shift register and synchronizer cleared to 0.
- DIN passes through a 2-FF synchronizer. Edges are detected on the synchronized value against its previous sample. All timing is in synchronized-domain cycles.
- One saturating counter, 16 bits, measures the current level's duration. It resets to 1 on every edge.
- States:
  - SYNC: counts low time only; a high level restarts the count. After RESET_CYCLES of continuous low -> IDLE. No frame_done is emitted. Entered out of reset and after any error, so decoding never starts mid-frame.
  - IDLE: rising edge -> HIGH. Clear pixel_index and the bit counter. Clear frame_err.
  - HIGH: on falling edge with count < MIN_HIGH -> LOW, no bit. With MIN_HIGH ≤ count < BIT_THRESH, shift in 0 -> LOW. With count ≥ BIT_THRESH, shift in 1 -> LOW. If count reaches MAX_HIGH while still high: set frame_err -> SYNC.
  - LOW: rising edge -> HIGH. When count reaches RESET_CYCLES: frame end -> IDLE.
- Pixel assembly:
  - On the 24th shifted bit, pixel_valid asserts in the cycle after the falling-edge detection, with pixel_data = shift contents and pixel_index = current index.
  - The index then increments and saturates at all-ones. Saturation sets frame_err; decoding continues.
- Latency: DIN falling edge of a pixel's last bit to pixel_valid = 4 CLK cycles (2 sync + 1 edge + 1 register).
- Frame end:
  - frame_done pulses for one cycle, with frame_pixels = number of pixel_valid strobes in the frame.
  - If the bit counter ≠ 0 (partial pixel), set frame_err and discard the partial bits.
  - A frame with zero bits cannot reach LOW, so it never produces frame_done.
- pixel_valid and frame_done are never asserted in the same cycle: the end-of-gap count always trails the last bit by ≥ RESET_CYCLES.
- Glitch pulses do not affect the bit counter, and the low count continues across them (the counter is not reset by a rejected pulse).
- Asynchronous reset asserted mid-frame: immediate return to reset values. Decoding restarts only after a full RESET_CYCLES low gap.

Decomposition:
- ws2812_pkg holds:
  - state enum (SYNC, IDLE, HIGH, LOW)
  - PIXEL_BITS = 24
  - default timing constants for 16 MHz, shared with the LED transmitter so both ends use one source for T0H/T1H/RESET.
- One natural sub-module: sync_edge (2-FF synchronizer plus rise/fall strobes), reusable for other PIN inputs.

Test Plan:
- Idle line low 800 cycles, then one pixel 0xFF00A5 (T1H=13, T0H=6, bit period 20): exactly one pixel_valid with data 0xFF00A5, index 0, 4 cycles after the last falling edge. After 800 low cycles: frame_done, frame_pixels=1, frame_err=0.
- Three pixels 0x000000, 0xFFFFFF, 0x123456 back-to-back, then latch: indices 0,1,2 in order with matching data; frame_pixels=3.
- 1-cycle high glitch inserted between bits 10 and 11 of 0xABCDEF: decoded pixel still 0xABCDEF, frame_err=0.
- 12 bits then an 800-cycle low gap: no pixel_valid; frame_done with frame_pixels=0 and frame_err=1. Next frame's first rising edge clears frame_err.
- DIN held high 40 cycles mid-pixel: frame_err=1 at cycle 32 of the high level. No frame_done until a full 800-cycle low gap, then a fresh pixel 0x0F0F0F decodes at index 0.
- Start of stimulus mid-pixel (no prior gap) and RST_N pulsed low during bit 5 of a later pixel: nothing decodes until an 800-cycle low gap. After the gap, the next pixel decodes correctly at index 0.
